// File: rtl/biu_pkg.sv
// Shared BIU definitions: interrupt-sequencer state encoding and ISR vector.
// Ports: none (package only).
// State codes are 3-bit constants so the bench can compare against them directly.
package biu_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SAVE    = 3'd1;
   localparam logic [2:0] ST_VECTOR  = 3'd2;
   localparam logic [2:0] ST_SERVICE = 3'd3;
   localparam logic [2:0] ST_RESTORE = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      SAVE    = ST_SAVE,
      VECTOR  = ST_VECTOR,
      SERVICE = ST_SERVICE,
      RESTORE = ST_RESTORE
   } int_state_e;

   // Address the IP register jumps to when its isr control is pulsed.
   localparam logic [31:0] ISR_VECTOR = 32'h0000_03FF;

endpackage

// File: rtl/int_ctrl32_edge_latch.sv
// Interrupt request edge detector plus pending flag.
// Ports: Clk, Reset_n, intr (raw request), clr (consume pending), pend (latched request).
// Latency: pend is high one edge after a rising intr edge is sampled.
module edge_latch (
   input  logic Clk,
   input  logic Reset_n,
   input  logic intr,
   input  logic clr,
   output logic pend
);

   logic intr_q, intr_d;
   logic pend_q, pend_d;

   always_comb begin
      intr_d = intr;
      // A fresh edge overrides a clear in the same cycle so it is never lost.
      pend_d = (intr & ~intr_q) | (pend_q & ~clr);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         intr_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         intr_q <= intr_d;
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/int_ctrl32.sv
// Interrupt sequencer driving the IP register controls (oe / isr / ld).
// Ports: Clk, Reset_n, intr, instr_done, ie_set, ie_clr, iret, ip_bus in;
//        ip_oe, ip_isr, ip_ld, ip_din, cpu_hold, inta, in_isr, ie out (all Moore).
module int_ctrl32
   import biu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             intr,
   input  logic             instr_done,
   input  logic             ie_set,
   input  logic             ie_clr,
   input  logic             iret,
   input  logic [WIDTH-1:0] ip_bus,
   output logic             ip_oe,
   output logic             ip_isr,
   output logic             ip_ld,
   output logic [WIDTH-1:0] ip_din,
   output logic             cpu_hold,
   output logic             inta,
   output logic             in_isr,
   output logic             ie
);

   int_state_e       state_q, state_d;
   logic             ie_q, ie_d;
   logic [WIDTH-1:0] ret_q, ret_d;
   logic             pend;
   logic             pend_clr;

   edge_latch u_edge (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .intr    (intr),
      .clr     (pend_clr),
      .pend    (pend)
   );

   // The request is consumed while the return address is being captured.
   assign pend_clr = (state_q == SAVE);

   // Next state, enable flag and return-address capture.
   always_comb begin
      state_d = state_q;
      ie_d    = ie_q;
      ret_d   = ret_q;

      if (ie_set) ie_d = 1'b1;
      if (ie_clr) ie_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pend && ie_q && instr_done) begin
               state_d = SAVE;
               ie_d    = 1'b0;   // mask further requests while servicing
            end
         end
         SAVE: begin
            ret_d   = ip_bus;
            state_d = VECTOR;
         end
         VECTOR: begin
            state_d = SERVICE;
         end
         SERVICE: begin
            if (iret) state_d = RESTORE;
         end
         RESTORE: begin
            ie_d    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         ie_q    <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         ie_q    <= ie_d;
         ret_q   <= ret_d;
      end
   end

   // Moore output decode; each IP control is owned by exactly one state.
   always_comb begin
      ip_oe    = 1'b0;
      ip_isr   = 1'b0;
      ip_ld    = 1'b0;
      ip_din   = '0;
      cpu_hold = 1'b0;
      inta     = 1'b0;
      in_isr   = 1'b0;
      unique case (state_q)
         SAVE: begin
            ip_oe    = 1'b1;
            inta     = 1'b1;
            cpu_hold = 1'b1;
         end
         VECTOR: begin
            ip_isr   = 1'b1;
            cpu_hold = 1'b1;
         end
         SERVICE: begin
            in_isr   = 1'b1;
         end
         RESTORE: begin
            ip_ld    = 1'b1;
            ip_din   = ret_q;
            cpu_hold = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign ie = ie_q;

endmodule

// File: tb/tb_int_ctrl32.sv
module tb_int_ctrl32;
   import biu_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic        intr = 1'b0;
   logic        instr_done = 1'b0;
   logic        ie_set = 1'b0;
   logic        ie_clr = 1'b0;
   logic        iret = 1'b0;
   logic [31:0] ip_bus;
   logic        ip_oe, ip_isr, ip_ld, cpu_hold, inta, in_isr, ie;
   logic [31:0] ip_din;

   int total = 0;
   int bad = 0;

   // Behavioural IP register: preload from the bench, isr -> vector, ld -> din.
   logic        pre_vld = 1'b0;
   logic [31:0] pre_dat = '0;
   logic [31:0] ip_reg = '0;
   int          hold_cnt = 0;
   logic        hold_clr = 1'b0;

   always @(posedge Clk) begin
      if (pre_vld)     ip_reg <= pre_dat;
      else if (ip_isr) ip_reg <= ISR_VECTOR;
      else if (ip_ld)  ip_reg <= ip_din;
      if (hold_clr)      hold_cnt <= 0;
      else if (cpu_hold) hold_cnt <= hold_cnt + 1;
   end
   assign ip_bus = ip_reg;

   always #5 Clk = ~Clk;

   int_ctrl32 #(.WIDTH(32)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .intr       (intr),
      .instr_done (instr_done),
      .ie_set     (ie_set),
      .ie_clr     (ie_clr),
      .iret       (iret),
      .ip_bus     (ip_bus),
      .ip_oe      (ip_oe),
      .ip_isr     (ip_isr),
      .ip_ld      (ip_ld),
      .ip_din     (ip_din),
      .cpu_hold   (cpu_hold),
      .inta       (inta),
      .in_isr     (in_isr),
      .ie         (ie)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 after the edge.
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   int inta_cnt;

   initial begin
      // ---------------- reset ----------------
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_oe",    {31'd0, ip_oe}, 0);
      chk("rst_isr",   {31'd0, ip_isr}, 0);
      chk("rst_ld",    {31'd0, ip_ld}, 0);
      chk("rst_din",   ip_din, 0);
      chk("rst_hold",  {31'd0, cpu_hold}, 0);
      chk("rst_inta",  {31'd0, inta}, 0);
      chk("rst_inisr", {31'd0, in_isr}, 0);
      chk("rst_ie",    {31'd0, ie}, 0);
      cyc();
      cyc();
      Reset_n = 1'b1;

      // ---------------- basic service ----------------
      ie_set = 1'b1; pre_vld = 1'b1; pre_dat = 32'h0000_0120;
      cyc();
      ie_set = 1'b0; pre_vld = 1'b0;
      chk("b_ie", {31'd0, ie}, 1);
      chk("b_ip_pre", ip_reg, 32'h120);
      intr = 1'b1; hold_clr = 1'b1;
      cyc();
      hold_clr = 1'b0;
      chk("b_pend", {31'd0, dut.u_edge.pend}, 1);
      chk("b_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      instr_done = 1'b1;
      cyc();                                   // SAVE
      instr_done = 1'b0; intr = 1'b0;
      chk("b_save_st", {29'd0, dut.state_q}, {29'd0, ST_SAVE});
      chk("b_inta",    {31'd0, inta}, 1);
      chk("b_oe",      {31'd0, ip_oe}, 1);
      chk("b_ie_off",  {31'd0, ie}, 0);
      cyc();                                   // VECTOR
      chk("b_inta_1cy", {31'd0, inta}, 0);
      chk("b_vec_isr",  {31'd0, ip_isr}, 1);
      chk("b_vec_oe",   {31'd0, ip_oe}, 0);
      chk("b_pend_clr", {31'd0, dut.u_edge.pend}, 0);
      cyc();                                   // SERVICE
      chk("b_ip_vec",  ip_reg, 32'h3FF);
      chk("b_in_isr",  {31'd0, in_isr}, 1);
      chk("b_svc_hold", {31'd0, cpu_hold}, 0);
      cyc();
      chk("b_svc_stay", {29'd0, dut.state_q}, {29'd0, ST_SERVICE});
      iret = 1'b1;
      cyc();                                   // RESTORE
      iret = 1'b0;
      chk("b_ld",   {31'd0, ip_ld}, 1);
      chk("b_din",  ip_din, 32'h120);
      chk("b_rhold", {31'd0, cpu_hold}, 1);
      cyc();                                   // IDLE
      chk("b_ip_ret", ip_reg, 32'h120);
      chk("b_ie_back", {31'd0, ie}, 1);
      chk("b_din0", ip_din, 0);
      chk("b_hold3", hold_cnt, 3);
      chk("b_idle2", {29'd0, dut.state_q}, {29'd0, ST_IDLE});

      // ---------------- masked request ----------------
      ie_clr = 1'b1;
      cyc();
      ie_clr = 1'b0;
      chk("m_ie0", {31'd0, ie}, 0);
      intr = 1'b1; instr_done = 1'b1;
      inta_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (inta) inta_cnt++;
      end
      chk("m_no_inta", inta_cnt, 0);
      ie_set = 1'b1;
      cyc();
      ie_set = 1'b0;
      chk("m_still_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      cyc();
      chk("m_inta", {31'd0, inta}, 1);
      intr = 1'b0; instr_done = 1'b0;
      cyc(); cyc();
      chk("m_svc", {31'd0, in_isr}, 1);
      iret = 1'b1;
      cyc();
      iret = 1'b0;
      cyc();
      chk("m_back_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});

      // ---------------- boundary gating ----------------
      intr = 1'b1;
      cyc();
      intr = 1'b0;
      chk("g_pend", {31'd0, dut.u_edge.pend}, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("g_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
         chk("g_hold", {31'd0, cpu_hold}, 0);
      end
      instr_done = 1'b1;
      cyc();
      instr_done = 1'b0;
      chk("g_save", {31'd0, inta}, 1);
      cyc(); cyc();                            // SERVICE

      // ---------------- nested edge ----------------
      intr = 1'b1;
      cyc();
      intr = 1'b0;
      chk("n_pend", {31'd0, dut.u_edge.pend}, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("n_no_reentry", {29'd0, dut.state_q}, {29'd0, ST_SERVICE});
      end
      iret = 1'b1;
      cyc();
      iret = 1'b0;
      cyc();
      chk("n_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      chk("n_pend_kept", {31'd0, dut.u_edge.pend}, 1);
      instr_done = 1'b1;
      cyc();                                   // second SAVE
      instr_done = 1'b0;
      chk("n_second", {31'd0, inta}, 1);

      // ---------------- new edge during SAVE ----------------
      intr = 1'b1;
      cyc();                                   // VECTOR
      intr = 1'b0;
      chk("s_vector", {29'd0, dut.state_q}, {29'd0, ST_VECTOR});
      chk("s_pend_set_wins", {31'd0, dut.u_edge.pend}, 1);

      // ---------------- reset mid-operation ----------------
      Reset_n = 1'b0;
      #1;
      chk("r_isr", {31'd0, ip_isr}, 0);
      chk("r_hold", {31'd0, cpu_hold}, 0);
      chk("r_ld", {31'd0, ip_ld}, 0);
      chk("r_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      chk("r_pend", {31'd0, dut.u_edge.pend}, 0);
      cyc();
      Reset_n = 1'b1;

      // ---------------- simultaneous set/clear ----------------
      ie_set = 1'b1;
      cyc();
      chk("e_set", {31'd0, ie}, 1);
      ie_clr = 1'b1;
      cyc();
      ie_set = 1'b0; ie_clr = 1'b0;
      chk("e_clr_wins", {31'd0, ie}, 0);

      // ---------------- stray iret ----------------
      iret = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("i_no_ld", {31'd0, ip_ld}, 0);
         chk("i_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
      end
      iret = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
